spi_pkt_parser: RTL and testbench

SPI_PKT_PARSER -- requirements
Module: spi_pkt_parser

---
 rtl/spi_pkt_pkg.sv | 25 ++
 rtl/spi_pkt_buf.sv | 26 ++
 rtl/spi_pkt_parser.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_pkt_parser.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared definitions for the SPI packet parser: opcodes, error causes,
// FSM state encoding and the default payload depth.
package spi_pkt_pkg;

    localparam int         MAX_LEN_DEF = 16;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [7:0] PAD_BYTE    = 8'h00;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OPCODE   = 2'd1,
        ERR_LEN_CSUM = 2'd2,
        ERR_ABORT    = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_COMMIT,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/spi_pkt_buf.sv
// Payload staging buffer: one synchronous write port, one combinational read port.
module spi_pkt_buf
    import spi_pkt_pkg::*;
#(
    parameter int DEPTH = MAX_LEN_DEF,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_pkt_parser.sv
// Parses SPI byte packets (header, length, payload, XOR checksum) and, once the
// checksum matches, replays the buffered payload into the register file.
module spi_pkt_parser
    import spi_pkt_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 8
) (
    input  logic             SysClk,
    input  logic             Reset,
    input  logic             SPI_SS,
    input  logic [7:0]       rcMemData,
    input  logic             rcMemWE,
    input  logic [11:0]      rcMemAddr,
    output logic [5:0]       regWrAddr,
    output logic [7:0]       regWrData,
    output logic             regWrEn,
    input  logic             regWrBusy,
    output logic             pktDone,
    output logic             pktErr,
    output logic [1:0]       errCode,
    output logic [CNT_W-1:0] pktCount
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e            state_q, state_d;
    logic              ss_meta_q, ss_sync_q, ss_prev_q;
    logic [5:0]        start_q, start_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        xor_q, xor_d;
    logic              abort_q, abort_d;
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              pkt_done_q, pkt_done_d;
    logic              pkt_err_q, pkt_err_d;
    err_code_e         err_code_q, err_code_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

    logic              ss_rise;
    logic              buf_we;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  rd_idx;
    logic [7:0]        buf_rd_data;
    logic              addr_unused;

    assign addr_unused = ^rcMemAddr;
    assign ss_rise     = ss_sync_q & ~ss_prev_q;
    assign idx_inc     = idx_q + IDX_W'(1);
    // The first commit byte is fetched while the checksum arrives; later ones one ahead.
    assign rd_idx      = (state_q == ST_CSUM) ? '0 : idx_inc;
    assign buf_we      = (state_q == ST_DATA) && rcMemWE && !ss_rise;

    spi_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (SysClk),
        .we      (buf_we),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (rcMemData),
        .rd_addr (rd_idx[AW-1:0]),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        len_d       = len_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        abort_d     = abort_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_HDR: begin
                if (ss_rise) begin
                    state_d = ST_HDR;
                end else if (rcMemWE && rcMemData != PAD_BYTE) begin
                    if (rcMemData[7:6] == OP_WRITE) begin
                        start_d = rcMemData[5:0];
                        xor_d   = rcMemData;
                        state_d = ST_LEN;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_OPCODE;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_LEN: begin
                if (ss_rise) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_ABORT;
                    state_d    = ST_HDR;
                end else if (rcMemWE) begin
                    if (rcMemData == 8'h00 || int'(rcMemData) > MAX_LEN) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN_CSUM;
                        state_d    = ST_DRAIN;
                    end else begin
                        len_d   = rcMemData[IDX_W-1:0];
                        idx_d   = '0;
                        xor_d   = xor_q ^ rcMemData;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_ABORT;
                    state_d    = ST_HDR;
                end else if (rcMemWE) begin
                    xor_d = xor_q ^ rcMemData;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (ss_rise) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_ABORT;
                    state_d    = ST_HDR;
                end else if (rcMemWE) begin
                    if (rcMemData == xor_q) begin
                        idx_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = start_q;
                        wr_data_d = buf_rd_data;
                        abort_d   = 1'b0;
                        state_d   = ST_COMMIT;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN_CSUM;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_COMMIT: begin
                // Bytes arriving mid-commit are lost, so the rest of that packet is drained.
                if (rcMemWE) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_ABORT;
                    abort_d    = 1'b1;
                end
                if (wr_en_q && !regWrBusy) begin
                    if (idx_inc == len_q) begin
                        wr_en_d     = 1'b0;
                        pkt_done_d  = 1'b1;
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                        abort_d     = 1'b0;
                        state_d     = (abort_q || rcMemWE) ? ST_DRAIN : ST_HDR;
                    end else begin
                        idx_d     = idx_inc;
                        wr_addr_d = wr_addr_q + 6'd1;
                        wr_data_d = buf_rd_data;
                    end
                end
            end
            ST_DRAIN: begin
                if (ss_rise) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (!Reset) begin
            state_q     <= ST_HDR;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            start_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            xor_q       <= '0;
            abort_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ss_meta_q   <= SPI_SS;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            start_q     <= start_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            abort_q     <= abort_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign regWrAddr = wr_addr_q;
    assign regWrData = wr_data_q;
    assign regWrEn   = wr_en_q;
    assign pktDone   = pkt_done_q;
    assign pktErr    = pkt_err_q;
    assign errCode   = err_code_q;
    assign pktCount  = pkt_count_q;

endmodule

// File: tb/tb_spi_pkt_parser.sv
// Self-checking bench for spi_pkt_parser: directed scenarios plus randomized
// packets compared against a byte-stream reference model.
module tb_spi_pkt_parser;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;

    typedef logic [7:0] bytes_t [$];
    typedef logic [13:0] writes_t [$];

    logic             SysClk    = 1'b0;
    logic             Reset     = 1'b0;
    logic             SPI_SS    = 1'b0;
    logic [7:0]       rcMemData = 8'h00;
    logic             rcMemWE   = 1'b0;
    logic [11:0]      rcMemAddr = 12'h000;
    logic             regWrBusy = 1'b0;
    logic [5:0]       regWrAddr;
    logic [7:0]       regWrData;
    logic             regWrEn;
    logic             pktDone;
    logic             pktErr;
    logic [1:0]       errCode;
    logic [CNT_W-1:0] pktCount;

    int checks    = 0;
    int errors    = 0;
    int cycle     = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int exp_count = 0;
    logic [13:0] wr_q [$];
    int          wr_cyc [$];

    spi_pkt_parser #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .SysClk    (SysClk),
        .Reset     (Reset),
        .SPI_SS    (SPI_SS),
        .rcMemData (rcMemData),
        .rcMemWE   (rcMemWE),
        .rcMemAddr (rcMemAddr),
        .regWrAddr (regWrAddr),
        .regWrData (regWrData),
        .regWrEn   (regWrEn),
        .regWrBusy (regWrBusy),
        .pktDone   (pktDone),
        .pktErr    (pktErr),
        .errCode   (errCode),
        .pktCount  (pktCount)
    );

    always #5 SysClk = ~SysClk;

    always @(posedge SysClk) cycle <= cycle + 1;

    // Monitor: record accepted register writes and event pulses mid-cycle.
    always @(negedge SysClk) begin
        if (Reset && regWrEn && !regWrBusy) begin
            wr_q.push_back({regWrAddr, regWrData});
            wr_cyc.push_back(cycle);
        end
        if (pktDone) done_cnt++;
        if (pktErr) err_cnt++;
        if (pktDone && pktErr) both_cnt++;
    end

    function automatic bytes_t make_pkt(input logic [5:0] start, input bytes_t payload, input bit corrupt);
        bytes_t p;
        logic [7:0] x;
        p.push_back({2'b01, start});
        p.push_back(8'(payload.size()));
        foreach (payload[i]) p.push_back(payload[i]);
        x = 8'h00;
        foreach (p[i]) x = x ^ p[i];
        if (corrupt) x = x ^ 8'(($urandom_range(1, 255)));
        p.push_back(x);
        return p;
    endfunction

    function automatic writes_t expect_writes(input logic [5:0] start, input bytes_t payload);
        writes_t w;
        foreach (payload[k]) w.push_back({6'((int'(start) + k) % 64), payload[k]});
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge SysClk);
        #1;
    endtask

    task automatic send_bytes(input bytes_t b);
        foreach (b[i]) begin
            rcMemData = b[i];
            rcMemWE   = 1'b1;
            @(posedge SysClk);
            #1;
            rcMemWE   = 1'b0;
        end
    endtask

    task automatic ss_pulse();
        SPI_SS = 1'b1;
        tick(6);
        SPI_SS = 1'b0;
        tick(4);
    endtask

    task automatic wait_done(input int target, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick(3);
        checks++; if (regWrEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_wren got %0b want 0", regWrEn); end
        checks++; if (pktDone !== 1'b0 || pktErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %0b%0b want 00", pktDone, pktErr); end
        checks++; if (errCode !== 2'd0) begin errors++; $display("[TB] FAIL reset_errcode got %0d want 0", errCode); end
        checks++; if (pktCount !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", pktCount); end
        checks++; if (regWrAddr !== 6'h00 || regWrData !== 8'h00) begin errors++; $display("[TB] FAIL reset_wrbus got %0h/%0h want 0/0", regWrAddr, regWrData); end
        Reset = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        bytes_t pl, pk;
        writes_t ew;
        bit ok;
        int d0;
        pl = '{8'hAA, 8'hBB, 8'hCC};
        pk = make_pkt(6'h01, pl, 1'b0);
        ew = expect_writes(6'h01, pl);
        wr_q.delete(); wr_cyc.delete();
        d0 = done_cnt;
        send_bytes(pk);
        checks++; if (regWrEn !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_wren got %0b want 1", regWrEn); end
        wait_done(d0 + 1, ok);
        exp_count++;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done timeout done=%0d want %0d", done_cnt, d0 + 1); end
        checks++; if (wr_q.size() != 3) begin errors++; $display("[TB] FAIL basic_nwrites got %0d want 3", wr_q.size()); end
        foreach (ew[k]) begin
            checks++;
            if (k >= wr_q.size() || wr_q[k] !== ew[k]) begin
                errors++; $display("[TB] FAIL basic_write%0d got %0h want %0h", k, (k < wr_q.size()) ? wr_q[k] : 14'h0, ew[k]);
            end
        end
        checks++; if (wr_cyc.size() == 3 && wr_cyc[2] - wr_cyc[0] != 2) begin errors++; $display("[TB] FAIL basic_consecutive got span %0d want 2", wr_cyc[2] - wr_cyc[0]); end
        checks++; if (pktCount !== CNT_W'(exp_count)) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", pktCount, exp_count); end
        checks++; if (errCode !== 2'd0) begin errors++; $display("[TB] FAIL basic_errcode got %0d want 0", errCode); end
    endtask

    task automatic test_wrap();
        bytes_t pl;
        writes_t ew;
        bit ok;
        logic [5:0] starts [2];
        starts[0] = 6'h3E;
        starts[1] = 6'h3F;
        pl = '{8'h11, 8'h22};
        for (int s = 0; s < 2; s++) begin
            wr_q.delete();
            ew = expect_writes(starts[s], pl);
            send_bytes(make_pkt(starts[s], pl, 1'b0));
            wait_done(done_cnt + 1, ok);
            exp_count++;
            checks++; if (!ok || wr_q.size() != 2) begin errors++; $display("[TB] FAIL wrap%0d_nwrites got %0d want 2", s, wr_q.size()); end
            foreach (ew[k]) begin
                checks++;
                if (k >= wr_q.size() || wr_q[k] !== ew[k]) begin
                    errors++; $display("[TB] FAIL wrap%0d_write%0d got %0h want %0h", s, k, (k < wr_q.size()) ? wr_q[k] : 14'h0, ew[k]);
                end
            end
        end
        checks++; if (pktCount !== CNT_W'(exp_count)) begin errors++; $display("[TB] FAIL wrap_count got %0d want %0d", pktCount, exp_count); end
    endtask

    task automatic test_bad_csum();
        int e0;
        wr_q.delete();
        e0 = err_cnt;
        send_bytes('{8'h41, 8'h02, 8'h10, 8'h20, 8'h00});
        tick(3);
        checks++; if (err_cnt != e0 + 1) begin errors++; $display("[TB] FAIL csum_err got %0d pulses want 1", err_cnt - e0); end
        checks++; if (errCode !== 2'd2) begin errors++; $display("[TB] FAIL csum_errcode got %0d want 2", errCode); end
        send_bytes('{8'h41, 8'h01, 8'h55, 8'h15});
        tick(8);
        checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL csum_drain got %0d writes want 0", wr_q.size()); end
        ss_pulse();
    endtask

    task automatic test_bad_len_opcode();
        bit ok;
        send_bytes('{8'h41, 8'h11});
        tick(2);
        checks++; if (errCode !== 2'd2) begin errors++; $display("[TB] FAIL len17_errcode got %0d want 2", errCode); end
        ss_pulse();
        send_bytes('{8'h41, 8'h00});
        tick(2);
        checks++; if (errCode !== 2'd2) begin errors++; $display("[TB] FAIL len0_errcode got %0d want 2", errCode); end
        ss_pulse();
        send_bytes('{8'hC5});
        tick(2);
        checks++; if (errCode !== 2'd1) begin errors++; $display("[TB] FAIL opcode_errcode got %0d want 1", errCode); end
        ss_pulse();
        wr_q.delete();
        send_bytes('{8'h00, 8'h00, 8'h41, 8'h01, 8'h55, 8'h15});
        wait_done(done_cnt + 1, ok);
        exp_count++;
        checks++; if (!ok || wr_q.size() != 1 || wr_q[0] !== {6'h01, 8'h55}) begin errors++; $display("[TB] FAIL padding_write got n=%0d w=%0h want n=1 w=0155", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 14'h0); end
    endtask

    task automatic test_ss_abort();
        int e0;
        bit ok;
        e0 = err_cnt;
        wr_q.delete();
        send_bytes('{8'h41, 8'h03, 8'hAA});
        SPI_SS = 1'b1;
        tick(6);
        checks++; if (err_cnt != e0 + 1 || errCode !== 2'd3) begin errors++; $display("[TB] FAIL ss_abort got pulses=%0d code=%0d want 1/3", err_cnt - e0, errCode); end
        SPI_SS = 1'b0;
        tick(4);
        send_bytes(make_pkt(6'h20, '{8'h5A}, 1'b0));
        wait_done(done_cnt + 1, ok);
        exp_count++;
        checks++; if (!ok || wr_q.size() != 1 || wr_q[0] !== {6'h20, 8'h5A}) begin errors++; $display("[TB] FAIL ss_recover got n=%0d want 1 write 205a", wr_q.size()); end
    endtask

    task automatic test_busy_and_reset();
        bytes_t pl;
        writes_t ew;
        bit ok;
        int e0;
        pl = '{8'hAA, 8'hBB, 8'hCC};
        ew = expect_writes(6'h01, pl);
        wr_q.delete();
        send_bytes(make_pkt(6'h01, pl, 1'b0));
        regWrBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge SysClk);
            checks++; if (regWrEn !== 1'b1 || regWrAddr !== 6'h01 || regWrData !== 8'hAA) begin errors++; $display("[TB] FAIL busy_hold%0d got %0b/%0h/%0h want 1/01/aa", i, regWrEn, regWrAddr, regWrData); end
            tick(1);
        end
        regWrBusy = 1'b0;
        wait_done(done_cnt + 1, ok);
        exp_count++;
        checks++; if (!ok || wr_q.size() != 3) begin errors++; $display("[TB] FAIL busy_nwrites got %0d want 3", wr_q.size()); end
        foreach (ew[k]) begin
            checks++;
            if (k >= wr_q.size() || wr_q[k] !== ew[k]) begin
                errors++; $display("[TB] FAIL busy_write%0d got %0h want %0h", k, (k < wr_q.size()) ? wr_q[k] : 14'h0, ew[k]);
            end
        end
        wr_q.delete();
        e0 = err_cnt;
        send_bytes(make_pkt(6'h08, pl, 1'b0));
        regWrBusy = 1'b1;
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        regWrBusy = 1'b0;
        exp_count = 0;
        tick(10);
        checks++; if (wr_q.size() != 0 || regWrEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit got %0d writes wren=%0b want 0/0", wr_q.size(), regWrEn); end
        checks++; if (err_cnt != e0 || pktCount !== '0) begin errors++; $display("[TB] FAIL reset_commit_err got pulses=%0d count=%0d want 0/0", err_cnt - e0, pktCount); end
    endtask

    task automatic test_commit_abort();
        bytes_t pl;
        writes_t ew;
        bit ok;
        int e0;
        pl = '{8'h01, 8'h02, 8'h03};
        ew = expect_writes(6'h10, pl);
        wr_q.delete();
        e0 = err_cnt;
        send_bytes(make_pkt(6'h10, pl, 1'b0));
        rcMemData = 8'h41;
        rcMemWE   = 1'b1;
        tick(1);
        rcMemWE   = 1'b0;
        wait_done(done_cnt + 1, ok);
        exp_count++;
        checks++; if (err_cnt != e0 + 1 || errCode !== 2'd3) begin errors++; $display("[TB] FAIL cabort_err got pulses=%0d code=%0d want 1/3", err_cnt - e0, errCode); end
        checks++; if (!ok || wr_q.size() != 3 || wr_q[2] !== ew[2]) begin errors++; $display("[TB] FAIL cabort_writes got n=%0d want 3", wr_q.size()); end
        checks++; if (pktCount !== CNT_W'(exp_count)) begin errors++; $display("[TB] FAIL cabort_count got %0d want %0d", pktCount, exp_count); end
        wr_q.delete();
        send_bytes(make_pkt(6'h00, '{8'h77}, 1'b0));
        tick(6);
        checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL cabort_drain got %0d writes want 0", wr_q.size()); end
        ss_pulse();
        send_bytes(make_pkt(6'h00, '{8'h77}, 1'b0));
        wait_done(done_cnt + 1, ok);
        exp_count++;
        checks++; if (!ok || wr_q.size() != 1 || wr_q[0] !== {6'h00, 8'h77}) begin errors++; $display("[TB] FAIL cabort_recover got n=%0d want 1", wr_q.size()); end
    endtask

    task automatic test_random();
        bytes_t pl, pk;
        writes_t ew;
        bit ok, corrupt;
        int len, e0;
        logic [5:0] start;
        for (int it = 0; it < 12; it++) begin
            pl.delete(); pk.delete();
            start   = 6'($urandom_range(0, 63));
            len     = (it == 0) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
            corrupt = (it != 0) && ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) pk.push_back(8'h00);
            pk = {pk, make_pkt(start, pl, corrupt)};
            ew = expect_writes(start, pl);
            wr_q.delete();
            e0 = err_cnt;
            send_bytes(pk);
            if (corrupt) begin
                tick(4);
                checks++; if (err_cnt != e0 + 1 || errCode !== 2'd2 || wr_q.size() != 0) begin errors++; $display("[TB] FAIL rand%0d_bad got pulses=%0d code=%0d writes=%0d want 1/2/0", it, err_cnt - e0, errCode, wr_q.size()); end
                ss_pulse();
            end else begin
                wait_done(done_cnt + 1, ok);
                exp_count++;
                checks++; if (!ok || wr_q.size() != ew.size()) begin errors++; $display("[TB] FAIL rand%0d_nwrites got %0d want %0d", it, wr_q.size(), ew.size()); end
                foreach (ew[k]) begin
                    if (k < wr_q.size() && wr_q[k] !== ew[k]) begin
                        checks++; errors++;
                        $display("[TB] FAIL rand%0d_write%0d got %0h want %0h", it, k, wr_q[k], ew[k]);
                    end
                end
                checks++; if (pktCount !== CNT_W'(exp_count)) begin errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", it, pktCount, exp_count); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bad_csum();
        test_bad_len_opcode();
        test_ss_abort();
        test_busy_and_reset();
        test_random();
        test_commit_abort();
        checks++; if (both_cnt != 0) begin errors++; $display("[TB] FAIL done_err_overlap got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
